// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-requester arbiter/sequencer in front of a single-port data memory.
// Port 0 is the CPU load/store path and port 1 is the debug/DMA loader. Each
// granted access is latched into command registers. It is then driven onto the
// memory for exactly one cycle and acknowledged in that same cycle. Read data
// is captured into a per-port holding register.
//
// Parameters
//   ADDR_W    address width, passed through unmodified
//   DATA_W    data width
//   LOCK_MAX  max consecutive grants to one port while the other waits (>=1)
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   p0_req/p0_we/p0_addr/p0_wdata   port 0 command (held until p0_ack)
//   p0_ack                     one-cycle pulse, port 0 access issued this cycle
//   p0_rdata                   port 0 last read data (holding register)
//   p1_*                       same as port 0, for port 1
//   mem_access_addr            memory address (holds the command register)
//   mem_write_data             memory write data (holds the command register)
//   mem_write_en, mem_read     memory strobes, only active in the access cycle
//   mem_read_data              combinational read data from the memory
//
// Configuration macro
//   MEM_ARB_ROUND_ROBIN_EN     when defined, a tie between two requesters with
//                              no active lock streak goes to the port that was
//                              not the last owner. When undefined, port 0 wins.
// -----------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int                CNT_W      = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0]  LOCK_MAX_C = CNT_W'(LOCK_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // Command registers: what the memory sees during ACCESS and holds afterwards.
  logic                r_cmd_we;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;

  // r_owner doubles as last_owner: it is only rewritten on a new grant.
  logic                r_owner;
  logic [CNT_W-1:0]    r_lock_cnt;

  logic [DATA_W-1:0]   r_p0_rdata;
  logic [DATA_W-1:0]   r_p1_rdata;

  logic                w_grant;
  logic                w_winner;
  logic [CNT_W-1:0]    w_lock_next;
  logic                w_access;

  // ---------------------------------------------------------------------------
  // Next-state and arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_winner     = r_owner;
    w_lock_next  = r_lock_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          w_grant      = 1'b1;
          w_next_state = S_ACCESS;

          if (!(p0_req && p1_req)) begin
            // A lone requester always wins, no idle penalty.
            w_winner = p1_req;
          end else if (r_lock_cnt == LOCK_MAX_C) begin
            // Streak exhausted: the waiting port takes over.
            w_winner = ~r_owner;
          end else if (r_lock_cnt != '0) begin
            // Streak still open: the last owner keeps the memory.
            w_winner = r_owner;
          end else begin
            // No streak yet (only right after reset).
`ifdef MEM_ARB_ROUND_ROBIN_EN
            w_winner = ~r_owner;
`else
            w_winner = 1'b0;
`endif
          end

          // Count consecutive grants. The count saturates at LOCK_MAX and
          // restarts at 1 when the grant moves to the other port.
          if (w_winner == r_owner) begin
            w_lock_next = (r_lock_cnt == LOCK_MAX_C) ? r_lock_cnt : r_lock_cnt + 1'b1;
          end else begin
            w_lock_next = CNT_ONE;
          end
        end
      end
      S_ACCESS: begin
        // Requests are ignored here. The memory gets exactly one cycle.
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, command and holding registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    if (reset) begin
      r_state     <= S_IDLE;
      r_cmd_we    <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_owner     <= 1'b1;
      r_lock_cnt  <= '0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_grant) begin
        r_owner     <= w_winner;
        r_lock_cnt  <= w_lock_next;
        r_cmd_we    <= w_winner ? p1_we    : p0_we;
        r_cmd_addr  <= w_winner ? p1_addr  : p0_addr;
        r_cmd_wdata <= w_winner ? p1_wdata : p0_wdata;
      end

      // A read completes at the end of its access cycle. Only the owner's
      // holding register changes, and a write never touches either register.
      if (r_state == S_ACCESS && !r_cmd_we) begin
        if (r_owner) r_p1_rdata <= mem_read_data;
        else         r_p0_rdata <= mem_read_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Gating with ~reset makes a reset during ACCESS cancel both the memory
  // strobe and the ack in that same cycle.
  assign w_access        = (r_state == S_ACCESS) && !reset;

  assign mem_write_en    = w_access &&  r_cmd_we;
  assign mem_read        = w_access && !r_cmd_we;
  assign mem_access_addr = r_cmd_addr;
  assign mem_write_data  = r_cmd_wdata;

  assign p0_ack          = w_access && !r_owner;
  assign p1_ack          = w_access &&  r_owner;
  assign p0_rdata        = r_p0_rdata;
  assign p1_rdata        = r_p1_rdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter. A behavioural model tracks which
// access is in flight, the grant streak and the expected memory contents. Every
// cycle it is compared with the DUT outputs. Directed scenarios come first.
// A randomized traffic phase follows.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam int LOCK_MAX = 1;
`else
  localparam int LOCK_MAX = 4;
`endif

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read;

  data_mem_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .p0_req         (p0_req),
    .p0_we          (p0_we),
    .p0_addr        (p0_addr),
    .p0_wdata       (p0_wdata),
    .p0_ack         (p0_ack),
    .p0_rdata       (p0_rdata),
    .p1_req         (p1_req),
    .p1_we          (p1_we),
    .p1_addr        (p1_addr),
    .p1_wdata       (p1_wdata),
    .p1_ack         (p1_ack),
    .p1_rdata       (p1_rdata),
    .mem_access_addr(mem_access_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory (written by the step task at each rising edge).
  logic [15:0] tb_mem [256];
  assign mem_read_data = tb_mem[mem_access_addr[7:0]];

  // Reference model state.
  logic [15:0] ref_mem [256];
  logic [15:0] m_rdata [2];
  bit          m_access;
  int          m_last;
  int          m_streak;
  bit          m_we;
  logic [15:0] m_addr, m_wdata;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_access   = 1'b0;
    m_last     = 1;
    m_streak   = 0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
  endtask

  // Winner from the arbitration rules: a lone requester wins. With two
  // requesters, an open streak keeps the last owner and a full streak hands
  // over. With no streak, the tie-break is port 0, or the non-last port in
  // round-robin mode.
  function automatic int pick(bit r0, bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (m_streak >= LOCK_MAX) return 1 - m_last;
    if (m_streak >= 1) return m_last;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return 1 - m_last;
`else
    return 0;
`endif
  endfunction

  task automatic set_port(input int p, input bit req, input bit we,
                          input logic [15:0] addr, input logic [15:0] wdata);
    if (p == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  function automatic bit ack_of(int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".p0_ack"},   p0_ack,          m_access && m_last == 0);
    check({tag, ".p1_ack"},   p1_ack,          m_access && m_last == 1);
    check({tag, ".mem_we"},   mem_write_en,    m_access && m_we);
    check({tag, ".mem_rd"},   mem_read,        m_access && !m_we);
    check({tag, ".mem_addr"}, mem_access_addr, m_addr);
    check({tag, ".mem_wd"},   mem_write_data,  m_wdata);
    check({tag, ".p0_rdata"}, p0_rdata,        m_rdata[0]);
    check({tag, ".p1_rdata"}, p1_rdata,        m_rdata[1]);
  endtask

  // Advance one clock. The model applies the edge, then the DUT is sampled.
  task automatic step();
    int          w;
    bit          wr_en;
    logic [7:0]  wr_a;
    logic [15:0] wr_d;
    wr_en = mem_write_en;
    wr_a  = mem_access_addr[7:0];
    wr_d  = mem_write_data;
    if (m_access) begin
      if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
      else      m_rdata[m_last]      = ref_mem[m_addr[7:0]];
      m_access = 1'b0;
    end else if (p0_req || p1_req) begin
      w = pick(p0_req, p1_req);
      if (w == m_last) m_streak = (m_streak < LOCK_MAX) ? m_streak + 1 : LOCK_MAX;
      else             m_streak = 1;
      m_last   = w;
      m_access = 1'b1;
      m_we     = (w == 1) ? p1_we    : p0_we;
      m_addr   = (w == 1) ? p1_addr  : p0_addr;
      m_wdata  = (w == 1) ? p1_wdata : p0_wdata;
    end
    @(posedge clk);
    if (wr_en) tb_mem[wr_a] = wr_d;
    #1;
    cyc++;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    check_outputs("reset");
  endtask

  // Issue one access from port p and wait (bounded) for its ack. Returns the
  // number of cycles from request to ack, then drops the request.
  task automatic run_access(input int p, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input string tag, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    set_port(p, 1, we, addr, wdata);
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      lat++;
      got = ack_of(p);
    end
    check({tag, ".acked"}, got, 1'b1);
    set_port(p, 0, we, addr, wdata);
  endtask

  task automatic new_cmd(input int p);
    bit r;
    r = ($urandom_range(0, 3) != 0);
    set_port(p, r, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p1_cnt;
    bit p0_seen;
    int ack_owner [8];
    int ack_cyc [8];
    int n_acks;

    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 16'h0;
      ref_mem[i] = 16'h0;
    end
    model_reset();
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("reset_init");

    // 1. Write then read at address 3, one-cycle latency each.
    run_access(0, 1, 16'd3, 16'hA5A5, "t1_wr", lat);
    check("t1_wr_latency", lat, 1);
    step();
    run_access(0, 0, 16'd3, 16'h0, "t1_rd", lat);
    check("t1_rd_latency", lat, 1);
    step();
    check("t1_rdata", p0_rdata, 16'hA5A5);

    // 2. Simultaneous requests from reset: p0 first, p1 two cycles later.
    do_reset();
    set_port(0, 1, 1, 16'd10, 16'h0A0A);
    set_port(1, 1, 1, 16'd11, 16'h0B0B);
    step();
    check("t2_p0_first", p0_ack, 1'b1);
    check("t2_p1_wait", p1_ack, 1'b0);
    set_port(0, 0, 0, 0, 0);
    step();
    check("t2_gap", p1_ack, 1'b0);
    step();
    check("t2_p1_second", p1_ack, 1'b1);
    set_port(1, 0, 0, 0, 0);
    step();

    // 3. p1 streams reads and gets the grant first. p0 then requests
    // continuously, and p1 keeps at most LOCK_MAX grants in a row.
    do_reset();
    set_port(1, 1, 0, 16'd3, 16'h0);
    p1_cnt  = 0;
    p0_seen = 1'b0;
    for (int k = 0; k < 40 && !p0_seen; k++) begin
      step();
      if (p1_ack) begin
        p1_cnt++;
        set_port(1, 1, 0, 16'($urandom_range(0, 15)), 16'h0);
        set_port(0, 1, 0, 16'd10, 16'h0);
      end
      if (p0_ack) p0_seen = 1'b1;
    end
    check("t3_p0_acked", p0_seen, 1'b1);
    check("t3_p1_acks", p1_cnt, LOCK_MAX);
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    step();

    // 4. Both request continuously. Grants change hands every LOCK_MAX
    // grants, with each ack two cycles after the previous one.
    do_reset();
    set_port(0, 1, 0, 16'd1, 16'h0);
    set_port(1, 1, 0, 16'd2, 16'h0);
    n_acks = 0;
    for (int k = 0; k < 40 && n_acks < 8; k++) begin
      step();
      if (p0_ack || p1_ack) begin
        ack_owner[n_acks] = p1_ack ? 1 : 0;
        ack_cyc[n_acks]   = cyc;
        n_acks++;
      end
    end
    check("t4_ack_count", n_acks, 8);
    for (int k = 0; k < 8 && k < n_acks; k++) begin
      check($sformatf("t4_owner%0d", k), ack_owner[k], (k / LOCK_MAX) % 2);
      if (k > 0) check($sformatf("t4_gap%0d", k), ack_cyc[k] - ack_cyc[k-1], 2);
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    step();

    // 5. Reset during p1's write access to address 5.
    do_reset();
    set_port(1, 1, 1, 16'd5, 16'h1234);
    step();
    check("t5_ack_before_reset", p1_ack, 1'b1);
    reset = 1'b1;
    #1;
    check("t5_ack_gated", p1_ack, 1'b0);
    check("t5_we_gated", mem_write_en, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    set_port(1, 0, 0, 0, 0);
    reset = 1'b0;
    check_outputs("t5_after");
    check("t5_mem5", tb_mem[5], ref_mem[5]);
    check("t5_mem5_old", tb_mem[5], 16'h0);

    // 6. Read data holds across a later write from the same port.
    do_reset();
    run_access(0, 1, 16'd7, 16'h00FF, "t6_wr", lat);
    step();
    run_access(0, 0, 16'd7, 16'h0, "t6_rd", lat);
    step();
    check("t6_rdata", p0_rdata, 16'h00FF);
    run_access(0, 1, 16'd7, 16'h1111, "t6_wr2", lat);
    step();
    step();
    check("t6_rdata_hold", p0_rdata, 16'h00FF);
    check("t6_p1_rdata", p1_rdata, 16'h0);

    // Randomized traffic. Each requester holds its command until acked.
    for (int k = 0; k < 600; k++) begin
      step();
      if (p0_ack || !p0_req) new_cmd(0);
      if (p1_ack || !p1_req) new_cmd(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
